// File: rtl/jtcop_obj_dma.sv
// Object-table DMA: on a CPU request, waits for vblank, copies 1024 words of
// object RAM into the hidden half of the double-buffered table, then flips banks.
module jtcop_obj_dma #(
    parameter int AW = 10
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          LVBL,
    input  logic          obj_copy,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_dout,
    output logic [AW:0]   dst_addr,
    output logic [15:0]   dst_din,
    output logic          dst_we,
    output logic          dst_bank
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_copy_l;
    logic          r_pending;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_rd_a;
    logic          r_rd_v;
    logic          r_bank;

    logic          w_edge;
    logic          w_start;
    logic          w_last;

    assign w_edge  = obj_copy & ~r_copy_l;
    assign w_start = (r_state == ST_IDLE) && r_pending && !LVBL;
    assign w_last  = (r_cnt == {AW{1'b1}});

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every variable gets a default first so the comb block cannot infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_COPY;
            ST_COPY:  if (w_last)  w_next = ST_FLUSH;
            ST_FLUSH: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_copy_l  <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_rd_v    <= 1'b0;
            r_rd_a    <= '0;
            r_bank    <= 1'b0;
        end else begin
            r_copy_l <= obj_copy;
            // A new request edge wins over consumption so it is never lost
            if (w_edge)       r_pending <= 1'b1;
            else if (w_start) r_pending <= 1'b0;

            if (w_start)                r_cnt <= '0;
            else if (r_state == ST_COPY) r_cnt <= r_cnt + 1'b1;

            // RAM read latency is one cycle, so the write side trails by one
            r_rd_v <= (r_state == ST_COPY);
            r_rd_a <= r_cnt;

            // Flip so the new bank is visible together with the done pulse
            if (r_state == ST_FLUSH) r_bank <= ~r_bank;
        end
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        src_addr = r_cnt;
        dst_we   = r_rd_v;
        dst_addr = {~r_bank, r_rd_a};
        dst_din  = src_dout;
        dst_bank = r_bank;
    end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Self-checking bench for jtcop_obj_dma: table of full copies plus hand-written
// sequences for idle, deferred start, queued request and reset mid-copy.
module tb_jtcop_obj_dma;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          LVBL;
    logic          obj_copy;
    logic          busy;
    logic          done;
    logic [AW-1:0] src_addr;
    logic [15:0]   src_dout;
    logic [AW:0]   dst_addr;
    logic [15:0]   dst_din;
    logic          dst_we;
    logic          dst_bank;

    logic [15:0] mem [1024];

    int n_pass  = 0;
    int n_total = 0;

    jtcop_obj_dma #(.AW(AW)) dut (
        .rst      (rst),
        .clk      (clk),
        .LVBL     (LVBL),
        .obj_copy (obj_copy),
        .busy     (busy),
        .done     (done),
        .src_addr (src_addr),
        .src_dout (src_dout),
        .dst_addr (dst_addr),
        .dst_din  (dst_din),
        .dst_we   (dst_we),
        .dst_bank (dst_bank)
    );

    always #5 clk = ~clk;

    // Synchronous object RAM, one-cycle read latency
    always @(posedge clk) src_dout <= mem[src_addr];

    typedef struct {
        logic [15:0] pat;
        int          rise_at;
        logic        exp_msb;
        logic        exp_bank;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] pat);
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ pat;
    endtask

    // Pulse obj_copy right after edge E; COPY must be visible after E+2
    task automatic start_copy(input logic [15:0] pat);
        load(pat);
        LVBL     = 1'b0;
        obj_copy = 1'b1;
        tick();
        obj_copy = 1'b0;
        check("busy_e1", {31'd0, busy}, 32'd0);
        tick();
        check("busy_e2", {31'd0, busy}, 32'd1);
    endtask

    // Called just after C0; follows the copy until busy drops
    task automatic watch_copy(input logic [15:0] pat, input logic exp_msb, input logic exp_bank,
                              input int rise_at, input int req_at);
        int   cyc = 0;
        int   nwr = 0;
        int   nerr = 0;
        int   first = -1;
        int   last = -1;
        int   ndone = 0;
        int   done_cyc = -1;
        logic bank_at_done = 1'bx;
        while (busy && cyc < 1200) begin
            obj_copy = (cyc == req_at);
            tick();
            cyc++;
            if (dst_we) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (dst_addr !== {exp_msb, 10'(nwr)} || dst_din !== (16'(nwr) ^ pat)) nerr++;
                nwr++;
                if (nwr == rise_at) LVBL = 1'b1;
            end
            if (done) begin
                ndone++;
                done_cyc     = cyc;
                bank_at_done = dst_bank;
            end
        end
        obj_copy = 1'b0;
        check("wr_count",   32'(nwr),      32'd1024);
        check("wr_errors",  32'(nerr),     32'd0);
        check("wr_first",   32'(first),    32'd1);
        check("wr_last",    32'(last),     32'd1024);
        check("done_count", 32'(ndone),    32'd1);
        check("done_cyc",   32'(done_cyc), 32'd1025);
        check("done_bank",  {31'd0, bank_at_done}, {31'd0, exp_bank});
        check("idle_cyc",   32'(cyc),      32'd1026);
    endtask

    initial begin
        int bad;
        int nwr;
        int guard;

        vecs[0] = '{pat: 16'hA5A5, rise_at: -1,  exp_msb: 1'b1, exp_bank: 1'b1};
        vecs[1] = '{pat: 16'h3C3C, rise_at: 300, exp_msb: 1'b0, exp_bank: 1'b0};
        vecs[2] = '{pat: 16'hFFFF, rise_at: -1,  exp_msb: 1'b1, exp_bank: 1'b1};

        // Reset and idle
        rst      = 1'b1;
        LVBL     = 1'b0;
        obj_copy = 1'b0;
        load(16'h0000);
        repeat (3) tick();
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_we",       {31'd0, dst_we},   32'd0);
        check("rst_src_addr", 32'(src_addr),     32'd0);
        check("rst_dst_addr", 32'(dst_addr),     32'h400);
        check("rst_bank",     {31'd0, dst_bank}, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (busy || dst_we || done || dst_bank || dst_addr !== 11'h400) bad++;
        end
        check("idle_2000", 32'(bad), 32'd0);

        // Full copies from the table
        for (int v = 0; v < 3; v++) begin
            start_copy(vecs[v].pat);
            watch_copy(vecs[v].pat, vecs[v].exp_msb, vecs[v].exp_bank, vecs[v].rise_at, -1);
            check("bank_after", {31'd0, dst_bank}, {31'd0, vecs[v].exp_bank});
            repeat (3) tick();
        end

        // Deferred start: request outside vblank waits for LVBL low
        load(16'h1234);
        LVBL     = 1'b1;
        obj_copy = 1'b1;
        tick();
        obj_copy = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (busy) bad++;
        end
        check("defer_wait", 32'(bad), 32'd0);
        LVBL = 1'b0;
        check("defer_pre", {31'd0, busy}, 32'd0);
        tick();
        check("defer_start", {31'd0, busy}, 32'd1);
        watch_copy(16'h1234, 1'b0, 1'b0, -1, -1);
        repeat (3) tick();

        // Queued request during COPY starts right after IDLE entry
        start_copy(16'hC3C3);
        watch_copy(16'hC3C3, 1'b1, 1'b1, -1, 400);
        tick();
        check("queue_start", {31'd0, busy}, 32'd1);
        watch_copy(16'hC3C3, 1'b0, 1'b0, -1, -1);
        check("queue_bank", {31'd0, dst_bank}, 32'd0);
        repeat (3) tick();

        // Reset mid-copy with bank at 1 beforehand
        start_copy(16'h7777);
        watch_copy(16'h7777, 1'b1, 1'b1, -1, -1);
        repeat (3) tick();
        start_copy(16'h1111);
        nwr   = 0;
        guard = 0;
        while (nwr < 600 && guard < 1200) begin
            tick();
            guard++;
            if (dst_we) nwr++;
        end
        check("rst_mid_reach", 32'(nwr), 32'd600);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we",   {31'd0, dst_we},   32'd0);
        check("rst_mid_busy", {31'd0, busy},     32'd0);
        check("rst_mid_bank", {31'd0, dst_bank}, 32'd0);
        check("rst_mid_addr", 32'(dst_addr),     32'h400);
        repeat (2) tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (done || busy || dst_we) bad++;
        end
        check("rst_mid_quiet", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
